// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the CPU data-port memory-map fabric.
package mem_bus_pkg;

    localparam int unsigned WAIT_W      = 4;
    localparam int unsigned FIELD_MAX_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Extract field i of a flattened per-slot parameter vector (LSB field = slot 0).
    function automatic logic [31:0] slot_field(
        input logic [FIELD_MAX_W-1:0] vec,
        input int unsigned            i,
        input int unsigned            width
    );
        logic [FIELD_MAX_W-1:0] sh;
        logic [31:0]            res;
        sh  = vec >> (i * width);
        res = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b < width) begin
                res[b] = sh[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Window decoder: range-compares the CPU address against every slot window,
// picks the lowest matching index and produces the slot-local offset.
module bus_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int unsigned                  NUM_SLOTS  = 2,
    parameter int unsigned                  ADDR_W     = 16,
    parameter logic [NUM_SLOTS*ADDR_W-1:0]  SLOT_BASE  = {16'h1000, 16'h0000},
    parameter logic [NUM_SLOTS*ADDR_W-1:0]  SLOT_LIMIT = {16'h10FF, 16'h07FF},
    localparam int unsigned                 SEL_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [SEL_W-1:0]  o_sel,
    output logic [ADDR_W-1:0] o_offset
);

    logic [ADDR_W-1:0]    w_base  [NUM_SLOTS];
    logic [ADDR_W-1:0]    w_limit [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] w_match;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_win
        assign w_base[g]  = ADDR_W'(slot_field(FIELD_MAX_W'(SLOT_BASE),  g, ADDR_W));
        assign w_limit[g] = ADDR_W'(slot_field(FIELD_MAX_W'(SLOT_LIMIT), g, ADDR_W));
        assign w_match[g] = (i_addr >= w_base[g]) && (i_addr <= w_limit[g]);
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        o_hit    = 1'b0;
        o_sel    = '0;
        o_offset = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit    = 1'b1;
                o_sel    = SEL_W'(i);
                o_offset = i_addr - w_base[i];
            end
        end
    end

endmodule

// File: rtl/mem_bus_fabric.sv
// Memory-map fabric between the CPU data port and NUM_SLOTS memory/IO slots:
// one-cycle slot strobe, per-slot wait states, registered read data, bus-error capture.
module mem_bus_fabric
    import mem_bus_pkg::*;
#(
    parameter int unsigned                  NUM_SLOTS  = 2,
    parameter int unsigned                  ADDR_W     = 16,
    parameter int unsigned                  DATA_W     = 8,
    parameter logic [NUM_SLOTS*ADDR_W-1:0]  SLOT_BASE  = {16'h1000, 16'h0000},
    parameter logic [NUM_SLOTS*ADDR_W-1:0]  SLOT_LIMIT = {16'h10FF, 16'h07FF},
    parameter logic [NUM_SLOTS*WAIT_W-1:0]  SLOT_WAIT  = {4'd0, 4'd0}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [DATA_W-1:0]             cpu_din,
    input  logic                          cpu_w_en,
    input  logic                          cpu_r_en,
    output logic [DATA_W-1:0]             cpu_dout,
    output logic                          cpu_ready,
    output logic [ADDR_W-1:0]             slot_addr,
    output logic [DATA_W-1:0]             slot_din,
    output logic [NUM_SLOTS-1:0]          slot_w_en,
    output logic [NUM_SLOTS-1:0]          slot_r_en,
    input  logic [NUM_SLOTS*DATA_W-1:0]   slot_dout,
    output logic                          bus_err,
    output logic [ADDR_W-1:0]             bus_err_addr,
    input  logic                          bus_err_clr
);

    localparam int unsigned SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic              w_hit;
    logic [SEL_W-1:0]  w_sel;
    logic [ADDR_W-1:0] w_offset;
    logic              w_req;

    logic [WAIT_W-1:0] w_slot_wait [NUM_SLOTS];
    logic [DATA_W-1:0] w_slot_rd   [NUM_SLOTS];

    state_t               r_state,        w_state_nxt;
    logic [SEL_W-1:0]     r_sel,          w_sel_nxt;
    logic                 r_is_wr,        w_is_wr_nxt;
    logic [WAIT_W-1:0]    r_wait_cnt,     w_wait_nxt;
    logic [DATA_W-1:0]    r_cpu_dout,     w_dout_nxt;
    logic                 r_ready,        w_ready_nxt;
    logic [ADDR_W-1:0]    r_slot_addr,    w_addr_nxt;
    logic [DATA_W-1:0]    r_slot_din,     w_din_nxt;
    logic [NUM_SLOTS-1:0] r_slot_w_en,    w_wen_nxt;
    logic [NUM_SLOTS-1:0] r_slot_r_en,    w_ren_nxt;
    logic                 r_bus_err,      w_err_nxt;
    logic [ADDR_W-1:0]    r_bus_err_addr, w_err_addr_nxt;

    bus_addr_decode #(
        .NUM_SLOTS  (NUM_SLOTS),
        .ADDR_W     (ADDR_W),
        .SLOT_BASE  (SLOT_BASE),
        .SLOT_LIMIT (SLOT_LIMIT)
    ) u_decode (
        .i_addr   (cpu_addr),
        .o_hit    (w_hit),
        .o_sel    (w_sel),
        .o_offset (w_offset)
    );

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign w_slot_wait[g] = WAIT_W'(slot_field(FIELD_MAX_W'(SLOT_WAIT), g, WAIT_W));
        assign w_slot_rd[g]   = slot_dout[g*DATA_W +: DATA_W];
    end

    assign w_req = cpu_w_en | cpu_r_en;

    // Next-state and next-output logic; every register keeps its value unless told otherwise.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_is_wr_nxt    = r_is_wr;
        w_wait_nxt     = r_wait_cnt;
        w_dout_nxt     = r_cpu_dout;
        w_ready_nxt    = 1'b0;
        w_addr_nxt     = r_slot_addr;
        w_din_nxt      = r_slot_din;
        w_wen_nxt      = '0;
        w_ren_nxt      = '0;
        w_err_nxt      = r_bus_err & ~bus_err_clr;
        w_err_addr_nxt = r_bus_err_addr;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_sel_nxt   = w_sel;
                        w_is_wr_nxt = cpu_w_en;
                        w_addr_nxt  = w_offset;
                        w_din_nxt   = cpu_din;
                        if (cpu_w_en) begin
                            w_wen_nxt = NUM_SLOTS'(1'b1) << w_sel;
                        end else begin
                            w_ren_nxt = NUM_SLOTS'(1'b1) << w_sel;
                        end
                        w_state_nxt = ST_ACCESS;
                    end else begin
                        // Error set overrides a same-cycle clear.
                        w_err_nxt      = 1'b1;
                        w_err_addr_nxt = cpu_addr;
                        if (!cpu_w_en) begin
                            w_dout_nxt = '0;
                        end
                        w_ready_nxt = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                w_wait_nxt  = w_slot_wait[r_sel];
                w_state_nxt = (w_slot_wait[r_sel] != '0) ? ST_WAIT : ST_CAPTURE;
            end
            ST_WAIT: begin
                w_wait_nxt = r_wait_cnt - WAIT_W'(1);
                if (r_wait_cnt <= WAIT_W'(1)) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!r_is_wr) begin
                    w_dout_nxt = w_slot_rd[r_sel];
                end
                w_ready_nxt = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_sel          <= '0;
            r_is_wr        <= 1'b0;
            r_wait_cnt     <= '0;
            r_cpu_dout     <= '0;
            r_ready        <= 1'b0;
            r_slot_addr    <= '0;
            r_slot_din     <= '0;
            r_slot_w_en    <= '0;
            r_slot_r_en    <= '0;
            r_bus_err      <= 1'b0;
            r_bus_err_addr <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sel          <= w_sel_nxt;
            r_is_wr        <= w_is_wr_nxt;
            r_wait_cnt     <= w_wait_nxt;
            r_cpu_dout     <= w_dout_nxt;
            r_ready        <= w_ready_nxt;
            r_slot_addr    <= w_addr_nxt;
            r_slot_din     <= w_din_nxt;
            r_slot_w_en    <= w_wen_nxt;
            r_slot_r_en    <= w_ren_nxt;
            r_bus_err      <= w_err_nxt;
            r_bus_err_addr <= w_err_addr_nxt;
        end
    end

    assign cpu_dout     = r_cpu_dout;
    assign cpu_ready    = r_ready;
    assign slot_addr    = r_slot_addr;
    assign slot_din     = r_slot_din;
    assign slot_w_en    = r_slot_w_en;
    assign slot_r_en    = r_slot_r_en;
    assign bus_err      = r_bus_err;
    assign bus_err_addr = r_bus_err_addr;

endmodule

// File: doc/mem_bus_fabric.md
Name: mem_bus_fabric

Overview:
Parametrised memory-map fabric between the CPU data port and N memory/IO slots, each with its own address window and wait-state count.
- Decodes each CPU access into a one-cycle strobe to exactly one slot.
- Presents a slot-local offset address.
- Captures read data into a register.
- Handshakes completion back with cpu_ready.
- Unmapped accesses raise a sticky bus-error flag and latch the faulting address.
- Replaces the fixed RAM/IO split in the SoC data-memory path.

Parameters:
NUM_SLOTS, 2, number of slave slots (1..8)
ADDR_W, 16, CPU address width
DATA_W, 8, data width
SLOT_BASE, {16'h1000,16'h0000}, flattened NUM_SLOTS*ADDR_W; slot i base at bits [i*ADDR_W +: ADDR_W]
SLOT_LIMIT, {16'h10FF,16'h07FF}, flattened inclusive upper bound per slot
SLOT_WAIT, {4'd0,4'd0}, flattened NUM_SLOTS*4; extra wait cycles per slot (0..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cpu_addr  in  ADDR_W  access address
cpu_din  in  DATA_W  write data
cpu_w_en  in  1  write request (level)
cpu_r_en  in  1  read request (level)
cpu_dout  out  DATA_W  registered read data
cpu_ready  out  1  one-cycle completion pulse
slot_addr  out  ADDR_W  offset from selected slot's base
slot_din  out  DATA_W  latched write data, broadcast to all slots
slot_w_en  out  NUM_SLOTS  one-hot write strobe
slot_r_en  out  NUM_SLOTS  one-hot read strobe
slot_dout  in  NUM_SLOTS*DATA_W  flattened slot read data
bus_err  out  1  sticky unmapped-access flag
bus_err_addr  out  ADDR_W  address of most recent unmapped access
bus_err_clr  in  1  clears bus_err

Behaviour:
- Clocking and reset: single clock domain on clk. rst is synchronous, active-high. All state changes on the rising edge of clk.
- Reset values: state IDLE; cpu_ready 0; cpu_dout 0; slot_w_en/slot_r_en 0; slot_addr 0; slot_din 0; bus_err 0; bus_err_addr 0.
- rst mid-transaction aborts immediately. Strobes are low in the cycle after the rst edge. No cpu_ready is issued.
- Decode: slot i matches when SLOT_BASE[i] <= cpu_addr <= SLOT_LIMIT[i]. On overlapping windows, the lowest index wins.
- Request qualification:
  - Requests are sampled only in IDLE.
  - cpu_w_en and cpu_r_en both high → treated as a write.
  - CPU inputs are ignored in all other states.
  - The CPU holds its request until cpu_ready.
- FSM states: IDLE, ACCESS, WAIT, CAPTURE, DONE.
  - IDLE + request + match: latch slot index, offset, cpu_din and direction → ACCESS.
  - IDLE + request + no match: set bus_err, load bus_err_addr = cpu_addr → DONE. cpu_dout is loaded with 0 if the access is a read.
  - ACCESS (1 cycle): exactly one bit of slot_w_en or slot_r_en is high. Wait counter loads SLOT_WAIT[i]. → WAIT if nonzero, else → CAPTURE.
  - WAIT: counter decrements each cycle; at 1 → CAPTURE. Strobes are low.
  - CAPTURE (1 cycle): on reads, cpu_dout <= slot_dout[i]. Writes leave cpu_dout unchanged. → DONE.
  - DONE: cpu_ready = 1 for exactly one cycle → IDLE. A request present during DONE is accepted in the following IDLE cycle.
- Latency (request seen in IDLE at cycle 0):
  - Mapped access: strobe at cycle 1, cpu_ready at cycle 3+W.
  - Unmapped access: cpu_ready at cycle 1.
  - Back-to-back mapped accesses with W=0: one every 4 cycles.
- Held outputs: slot_addr and slot_din hold their latched values from ACCESS through DONE. cpu_dout holds until the next read CAPTURE.
- Offset arithmetic: slot_addr = cpu_addr - SLOT_BASE[i], modulo 2^ADDR_W. It is never negative for a matched access.
- Error flag:
  - bus_err_clr clears bus_err; bus_err_addr is not cleared.
  - A new unmapped access in the same cycle as bus_err_clr: set wins.
  - Further errors overwrite bus_err_addr.
- Window boundaries: addresses exactly at a window's base or limit are mapped. Limit+1 with no other window covering it is unmapped.

Decomposition:
- Shared package mem_bus_pkg:
  - FSM state encoding (localparam ST_IDLE..ST_DONE).
  - WAIT_W = 4.
  - Helper function slot_field(vector, i, width) for flattened-parameter slicing.
- One combinational sub-module, bus_addr_decode:
  - Parameters NUM_SLOTS, ADDR_W, SLOT_BASE, SLOT_LIMIT.
  - Outputs: hit, sel index, offset.
  - Encapsulates range comparison and the priority encoder.

Test Plan:
- Read 0x0005 (slot 0, W=0), slot0 dout=8'hA5 → slot_r_en=2'b01 at cycle 1, slot_addr=0x0005; cpu_ready at cycle 3; cpu_dout=8'hA5.
- Write 0x1003 data 8'h3C with slot 1 W=2 → slot_w_en=2'b10 for one cycle, slot_addr=0x0003, slot_din=8'h3C; cpu_ready at cycle 5; cpu_dout unchanged.
- Read 0x0800 (unmapped) → no strobes, cpu_ready at cycle 1, cpu_dout=0, bus_err=1, bus_err_addr=0x0800. Then pulse bus_err_clr → bus_err=0, bus_err_addr still 0x0800.
- Boundaries: 0x07FF → slot 0; 0x1000 and 0x10FF → slot 1 with offsets 0x00/0xFF; 0x1100 → bus_err.
- cpu_w_en and cpu_r_en both high at 0x0010 → write strobe only. rst asserted during WAIT → strobes 0 and state IDLE next cycle, no cpu_ready; the next request completes normally.
- Overlap config (slot0 0x0000–0x0FFF, slot1 0x0800–0x08FF), access 0x0810 → slot 0 selected, slot_addr=0x0810. bus_err_clr coincident with an unmapped access → bus_err remains 1.
